// File: rtl/lpc_multi_decoder.sv
// lpc_multi_decoder: decodes LPC IO and memory read/write cycles from the LAD/LFRAME# bus.
// Ports:
//   lpc_clock        sole clock, rising edge
//   lpc_reset        asynchronous active-high reset
//   lpc_ad           LAD[3:0] bus nibble
//   lpc_frame        LFRAME#, active-low
//   out_cyctype_dir  captured CT/DIR nibble
//   out_addr         captured address, zero-extended
//   out_data         captured data, little-endian, zero-filled above size
//   out_data_size    transferred byte count (1, 2 or 4)
//   out_clock_enable one-cycle strobe, outputs valid while high
//   out_error        one-cycle strobe on SYNC error, timeout or unsupported size
module lpc_multi_decoder #(
   parameter int MAX_DATA_BYTES = 4,
   parameter int WAIT_LIMIT     = 64
) (
   input  logic                        lpc_clock,
   input  logic                        lpc_reset,
   input  logic [3:0]                  lpc_ad,
   input  logic                        lpc_frame,
   output logic [3:0]                  out_cyctype_dir,
   output logic [31:0]                 out_addr,
   output logic [8*MAX_DATA_BYTES-1:0] out_data,
   output logic [3:0]                  out_data_size,
   output logic                        out_clock_enable,
   output logic                        out_error
);
   localparam int WW = $clog2(WAIT_LIMIT + 1);
   localparam int DW = 8 * MAX_DATA_BYTES;
   typedef enum logic [3:0] {IDLE, CTDIR, SIZE, ADDR, TAR1, TAR2, SYNC, DATA, DONE} state_t;
   state_t          state_q, state_d;
   logic [3:0]      ct_q, ct_d, size_q, size_d, out_ct_q, out_ct_d, out_size_q, out_size_d;
   logic [31:0]     addr_q, addr_d, out_addr_q, out_addr_d;
   logic [DW-1:0]   data_q, data_d, out_data_q, out_data_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [WW-1:0]   wait_q, wait_d;
   logic            ce_q, ce_d, err_q, err_d;
   logic            io, wr, bad_size;
   logic [3:0]      size_code_bytes;
   logic [2:0]      last_nib;
   assign io              = ct_q[3:2] == 2'b00;
   assign wr              = ct_q[1];
   assign size_code_bytes = lpc_ad == 4'd0 ? 4'd1 : lpc_ad == 4'd1 ? 4'd2 : 4'd4;
   assign bad_size        = !(lpc_ad inside {4'd0, 4'd1, 4'd3}) || size_code_bytes > 4'(MAX_DATA_BYTES);
   assign last_nib        = size_q == 4'd1 ? 3'd1 : size_q == 4'd2 ? 3'd3 : 3'd7;
   always_comb begin
      state_d    = state_q;
      ct_d       = ct_q;
      size_d     = size_q;
      addr_d     = addr_q;
      data_d     = data_q;
      cnt_d      = cnt_q;
      wait_d     = wait_q;
      out_ct_d   = out_ct_q;
      out_addr_d = out_addr_q;
      out_data_d = out_data_q;
      out_size_d = out_size_q;
      ce_d       = 1'b0;
      err_d      = 1'b0;
      // LFRAME# low overrides everything: 0000 (re)starts, anything else aborts silently
      if (!lpc_frame) begin
         state_d = lpc_ad == 4'd0 ? CTDIR : IDLE;
      end else begin
         case (state_q)
            CTDIR: begin
               ct_d    = lpc_ad;
               addr_d  = '0;
               data_d  = '0;
               cnt_d   = '0;
               size_d  = 4'd1;
               state_d = lpc_ad[3:2] == 2'b00 ? ADDR : lpc_ad[3:2] == 2'b01 ? SIZE : IDLE;
            end
            SIZE: begin
               size_d  = size_code_bytes;
               err_d   = bad_size;
               state_d = bad_size ? IDLE : ADDR;
            end
            ADDR: begin
               addr_d = {addr_q[27:0], lpc_ad};
               cnt_d  = cnt_q + 3'd1;
               if (cnt_q == (io ? 3'd3 : 3'd7)) begin
                  cnt_d   = '0;
                  state_d = wr ? DATA : TAR1;
               end
            end
            TAR1: state_d = TAR2;
            TAR2: begin
               wait_d  = '0;
               state_d = SYNC;
            end
            SYNC: begin
               if (lpc_ad == 4'd0) begin
                  cnt_d   = '0;
                  ce_d    = wr;
                  state_d = wr ? DONE : DATA;
               end else if (lpc_ad == 4'd5 || lpc_ad == 4'd6) begin
                  wait_d = wait_q + 1'b1;
                  if (wait_q == WW'(WAIT_LIMIT - 1)) begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
            DATA: begin
               // nibble k of the data phase lands at bits [4k+3:4k]: low nibble first, byte 0 first
               for (int i = 0; i < 2 * MAX_DATA_BYTES; i++)
                  if (cnt_q == 3'(i)) data_d[4*i +: 4] = lpc_ad;
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == last_nib) begin
                  ce_d    = !wr;
                  state_d = wr ? TAR1 : DONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      if (ce_d) begin
         out_ct_d   = ct_q;
         out_addr_d = addr_q;
         out_data_d = data_d;
         out_size_d = size_q;
      end
   end
   always_ff @(posedge lpc_clock or posedge lpc_reset) begin
      if (lpc_reset) begin
         state_q    <= IDLE;
         ct_q       <= '0;
         size_q     <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         cnt_q      <= '0;
         wait_q     <= '0;
         out_ct_q   <= '0;
         out_addr_q <= '0;
         out_data_q <= '0;
         out_size_q <= '0;
         ce_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ct_q       <= ct_d;
         size_q     <= size_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         cnt_q      <= cnt_d;
         wait_q     <= wait_d;
         out_ct_q   <= out_ct_d;
         out_addr_q <= out_addr_d;
         out_data_q <= out_data_d;
         out_size_q <= out_size_d;
         ce_q       <= ce_d;
         err_q      <= err_d;
      end
   end
   assign out_cyctype_dir  = out_ct_q;
   assign out_addr         = out_addr_q;
   assign out_data         = out_data_q;
   assign out_data_size    = out_size_q;
   assign out_clock_enable = ce_q;
   assign out_error        = err_q;
endmodule

// File: tb/tb_lpc_multi_decoder.sv
// tb_lpc_multi_decoder: scoreboard bench for lpc_multi_decoder with directed LPC cycles.
module tb_lpc_multi_decoder;
   localparam int WL = 8;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  ad;
   logic        frame;
   logic [3:0]  ct, sz;
   logic [31:0] addr, data;
   logic        ce, err;
   int          errors = 0;
   int          checks = 0;
   typedef struct {
      bit          is_err;
      logic [3:0]  ct;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  size;
   } exp_t;
   exp_t q[$];
   exp_t e;
   lpc_multi_decoder #(.MAX_DATA_BYTES(4), .WAIT_LIMIT(WL)) dut (
      .lpc_clock(clk), .lpc_reset(rst), .lpc_ad(ad), .lpc_frame(frame),
      .out_cyctype_dir(ct), .out_addr(addr), .out_data(data), .out_data_size(sz),
      .out_clock_enable(ce), .out_error(err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic nib(input logic f, input logic [3:0] v);
      @(negedge clk);
      frame = f;
      ad    = v;
   endtask
   task automatic exp_ok(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      exp_t x;
      x.is_err = 1'b0; x.ct = c; x.addr = a; x.data = d; x.size = s;
      q.push_back(x);
   endtask
   task automatic exp_err();
      exp_t x;
      x.is_err = 1'b1; x.ct = '0; x.addr = '0; x.data = '0; x.size = '0;
      q.push_back(x);
   endtask
   // full bus cycle; read data is only driven when the final SYNC is ready
   task automatic xfer(input logic [3:0] c, input logic [3:0] scode, input logic [31:0] a,
                       input logic [31:0] d, input int nbytes, input int nwaits,
                       input logic [3:0] wn, input logic [3:0] fin, input bit tail);
      bit io;
      io = c[3:2] == 2'b00;
      nib(0, 4'h0);
      nib(1, c);
      if (!io) nib(1, scode);
      for (int i = (io ? 3 : 7); i >= 0; i--) nib(1, a[4*i +: 4]);
      if (c[1]) for (int i = 0; i < 2 * nbytes; i++) nib(1, d[4*i +: 4]);
      nib(1, 4'hF);
      nib(1, 4'hF);
      for (int i = 0; i < nwaits; i++) nib(1, wn);
      nib(1, fin);
      if (!c[1] && fin == 4'h0) for (int i = 0; i < 2 * nbytes; i++) nib(1, d[4*i +: 4]);
      if (tail) begin
         nib(1, 4'hF);
         nib(1, 4'hF);
         nib(1, 4'hF);
      end
   endtask
   always @(negedge clk) begin
      if (!rst && (ce || err)) begin
         chk("ce_err_exclusive", 64'(ce && err), 64'd0);
         if (q.size() == 0) begin
            chk("unexpected_event", {62'd0, ce, err}, 64'd0);
         end else begin
            e = q.pop_front();
            chk("event_kind", 64'(err), 64'(e.is_err));
            if (!e.is_err) begin
               chk("ct_dir", 64'(ct), 64'(e.ct));
               chk("addr", 64'(addr), 64'(e.addr));
               chk("data", 64'(data), 64'(e.data));
               chk("size", 64'(sz), 64'(e.size));
            end
         end
      end
   end
   initial begin
      rst = 1'b1; frame = 1'b1; ad = 4'hF;
      repeat (3) @(negedge clk);
      chk("rst_ct", 64'(ct), 64'd0);
      chk("rst_addr", 64'(addr), 64'd0);
      chk("rst_data", 64'(data), 64'd0);
      chk("rst_size", 64'(sz), 64'd0);
      chk("rst_ce_err", {62'd0, ce, err}, 64'd0);
      rst = 1'b0;
      exp_ok(4'h4, 32'hAFFE7FE5, 32'h0000DF6C, 4'd2);
      xfer(4'h4, 4'h1, 32'hAFFE7FE5, 32'h0000DF6C, 2, 0, 4'h6, 4'h0, 1);
      exp_ok(4'h2, 32'h00000080, 32'h0000005A, 4'd1);
      xfer(4'h2, 4'h0, 32'h00000080, 32'h0000005A, 1, 0, 4'h6, 4'h0, 1);
      exp_ok(4'h4, 32'h89ABCDEF, 32'h12345678, 4'd4);
      xfer(4'h4, 4'h3, 32'h89ABCDEF, 32'h12345678, 4, 3, 4'h6, 4'h0, 1);
      nib(0, 4'h0); nib(1, 4'h4); nib(1, 4'h3);
      nib(1, 4'h1); nib(1, 4'h2); nib(1, 4'h3); nib(1, 4'h4);
      nib(0, 4'hF); nib(1, 4'hF); nib(1, 4'hF);
      exp_ok(4'h0, 32'h00001234, 32'h000000A5, 4'd1);
      xfer(4'h0, 4'h0, 32'h00001234, 32'h000000A5, 1, 0, 4'h6, 4'h0, 1);
      exp_err();
      xfer(4'h4, 4'h0, 32'h11112222, 32'h00000033, 1, 1, 4'h5, 4'hA, 1);
      exp_err();
      xfer(4'h4, 4'h0, 32'h33334444, 32'h00000055, 1, WL + 1, 4'h6, 4'h0, 1);
      exp_ok(4'h6, 32'hFED00001, 32'h0000003C, 4'd1);
      xfer(4'h6, 4'h0, 32'hFED00001, 32'h0000003C, 1, WL - 1, 4'h5, 4'h0, 1);
      exp_err();
      xfer(4'h4, 4'h2, 32'h55556666, 32'h00007777, 2, 0, 4'h6, 4'h0, 1);
      exp_ok(4'h4, 32'h0000C000, 32'h00004321, 4'd2);
      xfer(4'h4, 4'h1, 32'h0000C000, 32'h00004321, 2, 0, 4'h6, 4'h0, 0);
      exp_ok(4'h6, 32'h00C0FFEE, 32'hCAFEF00D, 4'd4);
      xfer(4'h6, 4'h3, 32'h00C0FFEE, 32'hCAFEF00D, 4, 0, 4'h6, 4'h0, 1);
      repeat (3) @(negedge clk);
      chk("hold_addr", 64'(addr), 64'h00C0FFEE);
      nib(0, 4'h0); nib(1, 4'h4); nib(1, 4'h3);
      for (int i = 0; i < 8; i++) nib(1, 4'h9);
      nib(1, 4'hF); nib(1, 4'hF); nib(1, 4'h0);
      nib(1, 4'h1); nib(1, 4'h2); nib(1, 4'h3);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_ct", 64'(ct), 64'd0);
      chk("midrst_addr", 64'(addr), 64'd0);
      chk("midrst_data", 64'(data), 64'd0);
      chk("midrst_size", 64'(sz), 64'd0);
      chk("midrst_ce_err", {62'd0, ce, err}, 64'd0);
      @(negedge clk);
      rst = 1'b0; frame = 1'b0; ad = 4'h0;
      exp_ok(4'h6, 32'h00000010, 32'h0000BEEF, 4'd2);
      xfer(4'h6, 4'h1, 32'h00000010, 32'h0000BEEF, 2, 0, 4'h6, 4'h0, 1);
      repeat (4) @(negedge clk);
      chk("scoreboard_empty", 64'(q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
